vector_sum_serializer_12: RTL and testbench
===========================================

// Module: vector_sum_serializer_12
// PURPOSE
//  Downstream stage of the 12-element vector adder. Captures one 12-element sum vector
//  (S0..S11, IN_WIDTH+1 bits each) when the adder's outReady strobes, then streams the
//  elements out one per accepted beat, index 0 first, with valid/accept handshake and a
//  last flag. Lets serial consumers (memory writer, serial link) take adder results.
// PARAMETERS
//  IN_WIDTH  10  adder operand width; sum element and outData are IN_WIDTH+1 bits signed
//  (vector length fixed at 12; index counter is 4 bits)
// PORTS
//  clk                    in   1           clock, all state on rising edge
//  reset                  in   1           synchronous, active-high
//  enable                 in   1           clock enable; 0 freezes all state and outputs
//  inReady                in   1           S0..S11 valid this cycle (adder S0toS11outReady)
//  S0..S11                in   IN_WIDTH+1  signed sum elements
//  readyForNewDataSeries  out  1           block can capture a vector this cycle
//  outReady               out  1           outData valid
//  outAccept              in   1           consumer takes outData this cycle
//  outData                out  IN_WIDTH+1  signed current element
//  outIndex               out  4           index of outData, 0..11
//  outLast                out  1           outIndex==11 while outReady
// BEHAVIOUR
//  - Clock/reset as decided: single clk; reset synchronous, active-high, wins over enable.
//  - Reset values: state IDLE, idx 0, outReady 0, outData 0, outIndex 0, outLast 0,
//    element banks 0, readyForNewDataSeries 1.
//  - Capture: cap = enable & inReady & readyForNewDataSeries; on cap, S0..S11 are latched
//    into the stream bank, idx<=0, state<=STREAM. inReady with ready=0 is ignored (dropped).
//  - States: IDLE -(cap)-> STREAM; STREAM -(beat & idx==11 & !cap)-> IDLE;
//    STREAM -(beat & idx==11 & cap)-> STREAM with idx 0 and new vector (no bubble).
//    beat = enable & outReady & outAccept; on beat with idx<11, idx<=idx+1.
//  - Outputs are registered: outReady=1 exactly in STREAM; outData=bank[idx]; outIndex=idx;
//    outLast=(idx==11). Capture at edge N -> element 0 valid from edge N+1 (latency 1).
//  - outData/outIndex hold stable while outReady=1 and outAccept=0.
//  - readyForNewDataSeries (no double buffer) = (state==IDLE) | (outLast & outAccept),
//    combinational from outAccept; 0 in all other STREAM cycles.
//  - enable=0: no capture, no beat, no state change; outputs hold; ready forced 0.
//  - Reset mid-stream: next cycle IDLE with reset values; partially sent vector discarded.
//  - No arithmetic: elements pass bit-exact, sign preserved.
// CONFIGURATION
//  VEC_SER_DOUBLE_BUFFER_EN defined: adds a 12-element hold bank + holdFull flag.
//   ready = enable & !holdFull (registered holdFull). Capture in IDLE -> stream bank;
//   capture in STREAM -> hold bank, holdFull<=1. On last beat with holdFull: hold -> stream
//   bank, idx 0, holdFull<=0, stay STREAM (no bubble); a capture that same cycle lands in
//   hold, holdFull stays 1. Reset clears holdFull.
//  Not defined: single bank only, ready as in BEHAVIOUR; no hold-bank logic synthesized.
// TESTING
//  1 reset=1 2 cycles, enable=1 -> ready=1, outReady=0, outData=0, outIndex=0, outLast=0.
//  2 S_i=100*i-600, inReady 1 cycle, outAccept=1 -> outData -600,-500..500 on 12
//    consecutive cycles from capture+1; outLast only with 500; then IDLE, ready=1.
//  3 same vector, outAccept alternating 1,0 -> each element held 2 cycles, 24 cycles total,
//    order and values unchanged.
//  4 second vector S_i=-1024+i presented when outLast&outAccept -> -1024 follows 500
//    next cycle, no bubble; inReady pulse mid-stream (no double buffer) -> dropped.
//  5 enable=0 for 3 cycles at idx 5 -> outData=-100, outIndex=5 frozen; resumes at idx 6.
//  6 reset at idx 7 -> next cycle outReady=0, ready=1; with VEC_SER_DOUBLE_BUFFER_EN,
//    capture mid-stream -> ready=0 next cycle, second vector streams right after first.

Source files
------------

// File: rtl/vector_sum_serializer_12.sv
// Captures one 12-element sum vector from the adder and streams it out one element per accepted beat.
// Define VEC_SER_DOUBLE_BUFFER_EN to add a hold bank so a new vector can be taken while one is streaming.
module vector_sum_serializer_12 #(
    parameter int IN_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  inReady,
    input  logic signed [IN_WIDTH:0] S0,
    input  logic signed [IN_WIDTH:0] S1,
    input  logic signed [IN_WIDTH:0] S2,
    input  logic signed [IN_WIDTH:0] S3,
    input  logic signed [IN_WIDTH:0] S4,
    input  logic signed [IN_WIDTH:0] S5,
    input  logic signed [IN_WIDTH:0] S6,
    input  logic signed [IN_WIDTH:0] S7,
    input  logic signed [IN_WIDTH:0] S8,
    input  logic signed [IN_WIDTH:0] S9,
    input  logic signed [IN_WIDTH:0] S10,
    input  logic signed [IN_WIDTH:0] S11,
    output logic                  readyForNewDataSeries,
    output logic                  outReady,
    input  logic                  outAccept,
    output logic signed [IN_WIDTH:0] outData,
    output logic [3:0]            outIndex,
    output logic                  outLast,
    output logic                  dbg_state
);
    localparam int W = IN_WIDTH + 1;
    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    // Handshake: an element moves on a beat, i.e. a cycle where enable, outReady and
    // outAccept are all 1; outData/outIndex hold steady until that beat occurs.
    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [W-1:0]   bank_q [12];
    logic [W-1:0]   bank_d [12];
    logic           out_ready_q, out_ready_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [3:0]     out_index_q, out_index_d;
    logic           out_last_q, out_last_d;
    logic [W-1:0]   in_vec [12];
    logic           ready, cap, beat, last_beat;
`ifdef VEC_SER_DOUBLE_BUFFER_EN
    logic [W-1:0]   hold_q [12];
    logic [W-1:0]   hold_d [12];
    logic           hold_full_q, hold_full_d;
`endif

    assign in_vec[0]  = S0;
    assign in_vec[1]  = S1;
    assign in_vec[2]  = S2;
    assign in_vec[3]  = S3;
    assign in_vec[4]  = S4;
    assign in_vec[5]  = S5;
    assign in_vec[6]  = S6;
    assign in_vec[7]  = S7;
    assign in_vec[8]  = S8;
    assign in_vec[9]  = S9;
    assign in_vec[10] = S10;
    assign in_vec[11] = S11;

`ifdef VEC_SER_DOUBLE_BUFFER_EN
    assign ready = enable & ~hold_full_q;
`else
    // Single bank: only free when idle or while the last element is being taken.
    assign ready = enable & ((state_q == IDLE) | (out_last_q & outAccept));
`endif

    always_comb begin
        cap         = enable & inReady & ready;
        beat        = enable & out_ready_q & outAccept;
        last_beat   = beat & (idx_q == LAST_IDX);
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
`ifdef VEC_SER_DOUBLE_BUFFER_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        if (beat && !last_beat) begin
            idx_d = idx_q + 4'd1;
        end
`ifdef VEC_SER_DOUBLE_BUFFER_EN
        if (state_q == IDLE) begin
            if (cap) begin
                bank_d  = in_vec;
                idx_d   = 4'd0;
                state_d = STREAM;
            end
        end else if (last_beat) begin
            idx_d = 4'd0;
            if (hold_full_q) begin
                bank_d      = hold_q;
                hold_full_d = cap;
                if (cap) begin
                    hold_d = in_vec;
                end
            end else if (cap) begin
                bank_d = in_vec;
            end else begin
                state_d = IDLE;
            end
        end else if (cap) begin
            hold_d      = in_vec;
            hold_full_d = 1'b1;
        end
`else
        if (cap) begin
            bank_d  = in_vec;
            idx_d   = 4'd0;
            state_d = STREAM;
        end else if (last_beat) begin
            idx_d   = 4'd0;
            state_d = IDLE;
        end
`endif
        out_ready_d = (state_d == STREAM);
        out_data_d  = bank_d[idx_d];
        out_index_d = idx_d;
        out_last_d  = (state_d == STREAM) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            out_ready_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= 4'd0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                bank_q[i] <= '0;
            end
`ifdef VEC_SER_DOUBLE_BUFFER_EN
            hold_full_q <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                hold_q[i] <= '0;
            end
`endif
        end else if (enable) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_ready_q <= out_ready_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            bank_q      <= bank_d;
`ifdef VEC_SER_DOUBLE_BUFFER_EN
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
`endif
        end
    end

    assign readyForNewDataSeries = ready;
    assign outReady              = out_ready_q;
    assign outData               = out_data_q;
    assign outIndex              = out_index_q;
    assign outLast               = out_last_q;
    assign dbg_state             = state_q;
endmodule

// File: tb/tb_vector_sum_serializer_12.sv
// Bench for vector_sum_serializer_12: directed table, corner sequences and random traffic
// checked against an element-queue model of the stream.
module tb_vector_sum_serializer_12;
    localparam int W = 11;
`ifdef VEC_SER_DOUBLE_BUFFER_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable, inReady, outAccept;
    logic signed [W-1:0] s_in [12];
    logic readyForNewDataSeries, outReady, outLast, dbg_state;
    logic signed [W-1:0] outData;
    logic [3:0] outIndex;

    always #5 clk = ~clk;

    vector_sum_serializer_12 #(.IN_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
        .S0(s_in[0]), .S1(s_in[1]), .S2(s_in[2]), .S3(s_in[3]),
        .S4(s_in[4]), .S5(s_in[5]), .S6(s_in[6]), .S7(s_in[7]),
        .S8(s_in[8]), .S9(s_in[9]), .S10(s_in[10]), .S11(s_in[11]),
        .readyForNewDataSeries(readyForNewDataSeries), .outReady(outReady),
        .outAccept(outAccept), .outData(outData), .outIndex(outIndex),
        .outLast(outLast), .dbg_state(dbg_state)
    );

    typedef struct {
        logic               acc;
        logic signed [W-1:0] data;
        logic [3:0]         idx;
        logic               last;
        logic               valid;
        logic               ready;
    } vec_rec_t;

    int n_checks = 0;
    int n_fail = 0;
    logic [W+3:0] exp_q [$];          // {index, element} still owed by the DUT
    logic signed [W-1:0] vec_drv [12];
    logic signed [W-1:0] v1 [12];
    logic signed [W-1:0] v2 [12];
    logic obs_valid, obs_ready, obs_last;
    logic signed [W-1:0] obs_data;
    logic [3:0] obs_idx;
    vec_rec_t tbl [13];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive, sample at negedge against the model, advance model at posedge.
    task automatic step(input logic r, input logic e, input logic ir, input logic acc);
        logic exp_valid, exp_ready;
        logic [W+3:0] f;
        reset = r; enable = e; inReady = ir; outAccept = acc;
        for (int i = 0; i < 12; i++) s_in[i] = vec_drv[i];
        @(negedge clk);
        obs_valid = outReady; obs_ready = readyForNewDataSeries;
        obs_data = outData; obs_idx = outIndex; obs_last = outLast;
        exp_valid = (exp_q.size() != 0);
        if (DB_EN) exp_ready = e && (exp_q.size() <= 12);
        else       exp_ready = e && (exp_q.size() == 0 || (exp_q.size() == 1 && acc));
        if (!r) begin
            check("m_valid", outReady, exp_valid);
            check("m_ready", readyForNewDataSeries, exp_ready);
            if (exp_valid) begin
                f = exp_q[0];
                check("m_data", outData, $signed(f[W-1:0]));
                check("m_index", outIndex, f[W+3:W]);
                check("m_last", outLast, f[W+3:W] == 4'd11);
            end else begin
                check("m_last_idle", outLast, 0);
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (e && exp_valid && acc) void'(exp_q.pop_front());
            if (ir && exp_ready)
                for (int i = 0; i < 12; i++) exp_q.push_back({4'(i), vec_drv[i]});
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            v1[i] = W'(100 * i - 600);
            v2[i] = W'(-1024 + i);
            vec_drv[i] = '0;
        end
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{acc: 1'b1, data: W'(100 * i - 600), idx: 4'(i), last: (i == 11),
                       valid: 1'b1, ready: (DB_EN || i == 11)};
        end
        tbl[12] = '{acc: 1'b0, data: '0, idx: 4'd0, last: 1'b0, valid: 1'b0, ready: 1'b1};

        // Reset state
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("rst_ready", obs_ready, 1);
        check("rst_valid", obs_valid, 0);
        check("rst_data", obs_data, 0);
        check("rst_index", obs_idx, 0);
        check("rst_last", obs_last, 0);

        // Full-rate stream, table driven
        vec_drv = v1;
        step(0, 1, 1, 0);
        for (int k = 0; k < 13; k++) begin
            step(0, 1, 0, tbl[k].acc);
            check("tbl_valid", obs_valid, tbl[k].valid);
            check("tbl_ready", obs_ready, tbl[k].ready);
            check("tbl_last", obs_last, tbl[k].last);
            if (tbl[k].valid) begin
                check("tbl_data", obs_data, tbl[k].data);
                check("tbl_index", obs_idx, tbl[k].idx);
            end
        end

        // Alternating accept: every element shown for two cycles
        step(0, 1, 1, 0);
        for (int k = 0; k < 24; k++) begin
            step(0, 1, 0, (k % 2) == 1);
            check("alt_data", obs_data, W'(100 * (k / 2) - 600));
            check("alt_index", obs_idx, k / 2);
        end
        step(0, 1, 0, 0);
        check("alt_done", obs_valid, 0);

        // Back-to-back vectors with a mid-stream capture attempt
        vec_drv = v1;
        step(0, 1, 1, 0);
        vec_drv = v2;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, (k == 5 || k == 11), 1);
        end
        check("b2b_last_data", obs_data, 500);
        check("b2b_last_flag", obs_last, 1);
        if (!DB_EN) check("b2b_ready", obs_ready, 1);
        step(0, 1, 0, 1);
        check("b2b_next_valid", obs_valid, 1);
        check("b2b_next_data", obs_data, -1024);
        check("b2b_next_index", obs_idx, 0);
        for (int k = 0; k < 11; k++) step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check("b2b_done", obs_valid, 0);

        // Enable freeze at index 5
        vec_drv = v1;
        step(0, 1, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1);
            check("frz_data", obs_data, -100);
            check("frz_index", obs_idx, 5);
            check("frz_ready", obs_ready, 0);
        end
        step(0, 1, 0, 1);
        check("frz_resume_idx5", obs_idx, 5);
        step(0, 1, 0, 1);
        check("frz_resume_idx6", obs_idx, 6);
        check("frz_resume_data", obs_data, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1);

        // Reset mid-stream at index 7
        step(0, 1, 1, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check("mrst_index", obs_idx, 7);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("mrst_valid", obs_valid, 0);
        check("mrst_ready", obs_ready, 1);

        if (DB_EN) begin
            vec_drv = v1;
            step(0, 1, 1, 1);
            vec_drv = v2;
            step(0, 1, 1, 1);
            step(0, 1, 0, 1);
            check("db_ready_low", obs_ready, 0);
            for (int k = 0; k < 30 && exp_q.size() != 0; k++) step(0, 1, 0, 1);
        end

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 12; i++) vec_drv[i] = W'($urandom_range(0, 2047));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(0, 1, 0, 1);
        check("drain_empty", exp_q.size(), 0);
        step(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
